dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
Synthesizable DRAM-side responder for the MIG-style user interface that the ORAM top drives: accepts DRAM commands and write data, and returns read data. It is backed by an on-chip memory array and has a fixed read latency. It stands in for the DDR3 controller in simulation and in FPGA bring-up without physical DRAM, including the init-complete handshake the backend waits on.

Parameters:
DDRDWidth, 512, data beat width in bits; one command transfers one beat.
DDRMWidth, DDRDWidth/8, write mask width; one bit per byte.
DDRAWidth, 28, command address width.
DDRCWidth, 3, command code width.
BurstShift, 3, address LSBs dropped per beat (BL8); word index = DRAMAddress >> BurstShift.
MemDepthLog, 10, log2 of array depth in beats.
ReadLatency, 8, cycles from read-command acceptance to DRAMReadDataValid; must be >= 1.
WDataDepth, 4, write-data FIFO depth in beats; power of two.
InitCycles, 16, cycles after reset release before DRAMInitComplete rises.

Ports:
Clock  in  1  system clock; all logic on the rising edge.
Reset  in  1  synchronous, active-low reset.
DRAMAddress  in  DDRAWidth  command address.
DRAMCommand  in  DDRCWidth  command code: 3'b000 = write, 3'b001 = read, others = no-op.
DRAMCommandValid  in  1  command valid.
DRAMCommandReady  out  1  command accepted when Valid and Ready are both high.
DRAMWriteData  in  DDRDWidth  write beat.
DRAMWriteMask  in  DDRMWidth  1 = byte NOT written.
DRAMWriteDataValid  in  1  write beat valid.
DRAMWriteDataReady  out  1  high whenever the write-data FIFO is not full.
DRAMReadData  out  DDRDWidth  read beat.
DRAMReadDataValid  out  1  one-cycle strobe per read; no backpressure.
DRAMInitComplete  out  1  high once calibration emulation finishes.

Behaviour:
- Reset (Reset == 0 at a clock edge):
  - State goes to INIT; init counter, FIFO pointers and read pipeline valid bits are cleared.
  - All outputs are 0.
  - Array contents are not cleared. Mid-operation reset drops in-flight reads and queued write beats.
- FSM, INIT -> RUN:
  - INIT counts InitCycles cycles after reset deasserts, then moves to RUN and raises DRAMInitComplete, registered.
  - DRAMInitComplete stays high until the next reset.
  - In INIT, DRAMCommandReady = 0 and DRAMWriteDataReady = 0.
- Write-data FIFO:
  - Pushes on DRAMWriteDataValid && DRAMWriteDataReady, storing {mask, data}.
  - Data may lead its command by up to WDataDepth beats.
  - Push and pop in the same cycle are legal while full; the full flag is computed from the registered count.
- Command acceptance in RUN:
  - Read or no-op: Ready = 1.
  - Write: Ready = FIFO non-empty, or a beat is arriving this cycle (bypass path).
  - DRAMCommandReady is combinational on DRAMCommand and FIFO state only, never on DRAMCommandValid.
- Write commit:
  - On acceptance, pop the head beat and write the array at index (DRAMAddress >> BurstShift) mod 2^MemDepthLog, per byte where the mask bit is 0.
  - Out-of-range addresses wrap.
- Read:
  - On acceptance, read the array at the same index and push into a ReadLatency-deep valid/data shift pipeline.
  - Result appears on DRAMReadData with DRAMReadDataValid high exactly ReadLatency cycles later.
  - Reads return in order; back-to-back reads give back-to-back strobes.
- Ordering:
  - One command per cycle.
  - A read accepted after a write to the same index returns the new data, even if accepted the very next cycle (write-first).
- No-op command codes are accepted and ignored.

Optional Feature:
DRAM_RESPONDER_STALL_EN
- Defined: a 16-bit LFSR, seed 16'hACE1 and reset on Reset, gates DRAMCommandReady and DRAMWriteDataReady low on cycles where LFSR[1:0] == 2'b00. This exercises initiator backpressure.
- Undefined: no gating; Ready follows the rules above exactly.

Decomposition:
- Shared package dram_responder_pkg holds:
  - command codes DDR3CMD_Write and DDR3CMD_Read;
  - an index function taking (address, BurstShift, MemDepthLog);
  - the LFSR seed and tap constants.
- One natural sub-module: dram_responder_wfifo, the {mask, data} FIFO with count, full, empty and the same-cycle bypass.

Test Plan:
- Release reset, hold Valid high -> DRAMInitComplete rises at cycle InitCycles; no Ready before then.
- Write data 512'h5A..5A at address 28'h40 with mask 0, then read 28'h40 -> DRAMReadDataValid 8 cycles after read acceptance with 5A..5A.
- Write 512'hFF..FF to 28'h0, then write 0 to 28'h0 with mask = all ones except bit 0 -> read returns FF..FF00.
- Write command with no data for 5 cycles -> Ready stays 0; data arrives -> command accepted the same cycle via bypass.
- Push 4 data beats with no command -> DRAMWriteDataReady drops to 0; one write accepted -> Ready = 1 next cycle.
- Issue 3 back-to-back reads, then pull Reset low during cycle 4 -> no DRAMReadDataValid pulses after reset; a subsequent read still returns the pre-reset array contents.

Source files
------------

// File: rtl/dram_responder_pkg.sv
// rtl/dram_responder_pkg.sv - shared command codes, state type, index helper and LFSR constants
package dram_responder_pkg;

    localparam logic [2:0]  DDR3CMD_Write = 3'b000;
    localparam logic [2:0]  DDR3CMD_Read  = 3'b001;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    localparam logic [15:0] LfsrTaps = 16'hB400;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } dram_state_t;

    // Beat index into the backing array; high address bits wrap.
    function automatic logic [31:0] dram_index(input logic [31:0] address,
                                               input int burst_shift,
                                               input int mem_depth_log);
        return (address >> burst_shift) & ((32'd1 << mem_depth_log) - 32'd1);
    endfunction

endpackage

// File: rtl/dram_responder_wfifo.sv
// rtl/dram_responder_wfifo.sv - {mask, data} write-beat FIFO with same-cycle bypass
module dram_responder_wfifo #(
    parameter int DWidth = 512,
    parameter int MWidth = 64,
    parameter int Depth  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DWidth-1:0] push_data,
    input  logic [MWidth-1:0] push_mask,
    input  logic              pop,
    output logic [DWidth-1:0] head_data,
    output logic [MWidth-1:0] head_mask,
    output logic              full,
    output logic              empty
);
    localparam int PtrW = $clog2(Depth);

    logic [PtrW-1:0]          wr_ptr;
    logic [PtrW-1:0]          rd_ptr;
    logic [PtrW:0]            count;
    logic [MWidth+DWidth-1:0] mem [Depth];
    logic                     store;
    logic                     consume;

    // A beat popped while the FIFO is empty is taken straight off the input.
    assign store   = push && !(pop && empty);
    assign consume = pop && !empty;
    assign full    = (count == (PtrW+1)'(Depth));
    assign empty   = (count == '0);
    assign {head_mask, head_data} = empty ? {push_mask, push_data} : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + 1'b1;
            if (consume)
                rd_ptr <= rd_ptr + 1'b1;
            if (store && !consume)
                count <= count + 1'b1;
            else if (!store && consume)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr] <= {push_mask, push_data};
    end

endmodule

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - array-backed MIG-style DRAM responder; DRAM_RESPONDER_STALL_EN adds LFSR backpressure
module dram_responder #(
    parameter int DDRDWidth   = 512,
    parameter int DDRMWidth   = DDRDWidth/8,
    parameter int DDRAWidth   = 28,
    parameter int DDRCWidth   = 3,
    parameter int BurstShift  = 3,
    parameter int MemDepthLog = 10,
    parameter int ReadLatency = 8,
    parameter int WDataDepth  = 4,
    parameter int InitCycles  = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [DDRAWidth-1:0] DRAMAddress,
    input  logic [DDRCWidth-1:0] DRAMCommand,
    input  logic                 DRAMCommandValid,
    output logic                 DRAMCommandReady,
    input  logic [DDRDWidth-1:0] DRAMWriteData,
    input  logic [DDRMWidth-1:0] DRAMWriteMask,
    input  logic                 DRAMWriteDataValid,
    output logic                 DRAMWriteDataReady,
    output logic [DDRDWidth-1:0] DRAMReadData,
    output logic                 DRAMReadDataValid,
    output logic                 DRAMInitComplete
);
    import dram_responder_pkg::*;

    localparam int CntW = $clog2(InitCycles + 1);

    dram_state_t            state;
    logic [CntW-1:0]        init_cnt;
    logic                   stall;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   wdata_push;
    logic                   cmd_is_write;
    logic                   cmd_is_read;
    logic                   wr_fire;
    logic                   rd_fire;
    logic [MemDepthLog-1:0] idx;
    logic [DDRDWidth-1:0]   head_data;
    logic [DDRMWidth-1:0]   head_mask;
    logic [DDRDWidth-1:0]   mem [1 << MemDepthLog];
    logic [ReadLatency-1:0] rd_valid_pipe;
    logic [DDRDWidth-1:0]   rd_data_pipe [ReadLatency];

`ifdef DRAM_RESPONDER_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge Clock) begin
        if (!Reset)
            lfsr <= LfsrSeed;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LfsrTaps : 16'h0000);
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign cmd_is_write       = (DRAMCommand == DDRCWidth'(DDR3CMD_Write));
    assign cmd_is_read        = (DRAMCommand == DDRCWidth'(DDR3CMD_Read));
    assign DRAMWriteDataReady = (state == ST_RUN) && !fifo_full && !stall;
    assign wdata_push         = DRAMWriteDataValid && DRAMWriteDataReady;
    // A write needs a beat either queued or arriving on the bypass this cycle.
    assign DRAMCommandReady   = (state == ST_RUN) && !stall &&
                                (!cmd_is_write || !fifo_empty || wdata_push);
    assign wr_fire            = DRAMCommandValid && DRAMCommandReady && cmd_is_write;
    assign rd_fire            = DRAMCommandValid && DRAMCommandReady && cmd_is_read;
    assign idx                = MemDepthLog'(dram_index(32'(DRAMAddress), BurstShift, MemDepthLog));

    dram_responder_wfifo #(
        .DWidth (DDRDWidth),
        .MWidth (DDRMWidth),
        .Depth  (WDataDepth)
    ) u_wfifo (
        .clk       (Clock),
        .resetn    (Reset),
        .push      (wdata_push),
        .push_data (DRAMWriteData),
        .push_mask (DRAMWriteMask),
        .pop       (wr_fire),
        .head_data (head_data),
        .head_mask (head_mask),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state            <= ST_INIT;
            init_cnt         <= '0;
            DRAMInitComplete <= 1'b0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (init_cnt == CntW'(InitCycles - 1)) begin
                        state            <= ST_RUN;
                        DRAMInitComplete <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is deliberately not reset so contents survive a mid-run reset.
    always_ff @(posedge Clock) begin
        if (wr_fire) begin
            for (int b = 0; b < DDRMWidth; b++) begin
                if (!head_mask[b])
                    mem[idx][b*8 +: 8] <= head_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rd_valid_pipe <= '0;
            for (int i = 0; i < ReadLatency; i++)
                rd_data_pipe[i] <= '0;
        end else begin
            rd_valid_pipe[0] <= rd_fire;
            rd_data_pipe[0]  <= mem[idx];
            for (int i = 1; i < ReadLatency; i++) begin
                rd_valid_pipe[i] <= rd_valid_pipe[i-1];
                rd_data_pipe[i]  <= rd_data_pipe[i-1];
            end
        end
    end

    assign DRAMReadDataValid = rd_valid_pipe[ReadLatency-1];
    assign DRAMReadData      = rd_data_pipe[ReadLatency-1];

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - directed self-checking bench for dram_responder
module tb_dram_responder;

    localparam int LAT  = 8;
    localparam int INIT = 16;
    localparam logic [2:0] WR   = 3'b000;
    localparam logic [2:0] RD   = 3'b001;
    localparam logic [2:0] NOOP = 3'b111;

    logic         Clock;
    logic         Reset;
    logic [27:0]  DRAMAddress;
    logic [2:0]   DRAMCommand;
    logic         DRAMCommandValid;
    logic         DRAMCommandReady;
    logic [511:0] DRAMWriteData;
    logic [63:0]  DRAMWriteMask;
    logic         DRAMWriteDataValid;
    logic         DRAMWriteDataReady;
    logic [511:0] DRAMReadData;
    logic         DRAMReadDataValid;
    logic         DRAMInitComplete;

    int tests = 0;
    int fails = 0;

    logic [511:0] pat_5a;
    logic [511:0] pat_ff00;
    logic [511:0] pat_byp;

    dram_responder dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .DRAMAddress        (DRAMAddress),
        .DRAMCommand        (DRAMCommand),
        .DRAMCommandValid   (DRAMCommandValid),
        .DRAMCommandReady   (DRAMCommandReady),
        .DRAMWriteData      (DRAMWriteData),
        .DRAMWriteMask      (DRAMWriteMask),
        .DRAMWriteDataValid (DRAMWriteDataValid),
        .DRAMWriteDataReady (DRAMWriteDataReady),
        .DRAMReadData       (DRAMReadData),
        .DRAMReadDataValid  (DRAMReadDataValid),
        .DRAMInitComplete   (DRAMInitComplete)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic do_write(input logic [27:0] a, input logic [511:0] d,
                            input logic [63:0] m, input bit with_data);
        bit cmd_done;
        bit dat_done;
        cmd_done = 1'b0;
        dat_done = !with_data;
        @(negedge Clock);
        DRAMAddress        = a;
        DRAMCommand        = WR;
        DRAMCommandValid   = 1'b1;
        DRAMWriteData      = d;
        DRAMWriteMask      = m;
        DRAMWriteDataValid = with_data;
        for (int i = 0; i < 50 && !(cmd_done && dat_done); i++) begin
            #1;
            if (DRAMCommandValid && DRAMCommandReady) cmd_done = 1'b1;
            if (DRAMWriteDataValid && DRAMWriteDataReady) dat_done = 1'b1;
            @(posedge Clock);
            @(negedge Clock);
            if (cmd_done) DRAMCommandValid = 1'b0;
            if (dat_done) DRAMWriteDataValid = 1'b0;
        end
        DRAMCommandValid   = 1'b0;
        DRAMWriteDataValid = 1'b0;
        if (!(cmd_done && dat_done)) begin
            tests++; fails++;
            $display("FAIL write_handshake addr=%h: cmd_done=%0b dat_done=%0b, required both 1", a, cmd_done, dat_done);
        end
    endtask

    task automatic do_read(input logic [27:0] a, output int lat, output logic [511:0] d);
        bit acc;
        acc = 1'b0;
        lat = -1;
        d   = '0;
        @(negedge Clock);
        DRAMAddress      = a;
        DRAMCommand      = RD;
        DRAMCommandValid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            #1;
            if (DRAMCommandReady) acc = 1'b1;
            @(posedge Clock);
            @(negedge Clock);
        end
        DRAMCommandValid = 1'b0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL read_accept addr=%h: never accepted, required acceptance", a);
        end else begin
            for (int k = 1; k <= 20 && lat < 0; k++) begin
                if (k > 1) @(negedge Clock);
                if (DRAMReadDataValid) begin
                    lat = k;
                    d   = DRAMReadData;
                end
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        DRAMAddress = '0; DRAMCommand = NOOP; DRAMCommandValid = 1'b1;
        DRAMWriteData = '0; DRAMWriteMask = '0; DRAMWriteDataValid = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        tests++;
        if (DRAMInitComplete !== 1'b0) begin fails++; $display("FAIL reset_init got=%b exp=0", DRAMInitComplete); end
        tests++;
        if (DRAMCommandReady !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready got=%b exp=0", DRAMCommandReady); end
        tests++;
        if (DRAMWriteDataReady !== 1'b0) begin fails++; $display("FAIL reset_wd_ready got=%b exp=0", DRAMWriteDataReady); end
        tests++;
        if (DRAMReadDataValid !== 1'b0 || DRAMReadData !== '0) begin
            fails++; $display("FAIL reset_read_out got valid=%b data_nonzero=%b exp 0/0", DRAMReadDataValid, |DRAMReadData);
        end
    endtask

    task automatic test_init;
        int pulses;
        Reset = 1'b1;
        for (int i = 1; i <= INIT; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            #1;
            tests++;
            if (DRAMInitComplete !== (i == INIT)) begin
                fails++; $display("FAIL init_complete cycle=%0d got=%b exp=%b", i, DRAMInitComplete, i == INIT);
            end
            tests++;
            if (DRAMCommandReady !== (i == INIT) || DRAMWriteDataReady !== (i == INIT)) begin
                fails++; $display("FAIL init_ready cycle=%0d got cmd=%b wd=%b exp=%b", i, DRAMCommandReady, DRAMWriteDataReady, i == INIT);
            end
        end
        pulses = 0;
        repeat (LAT + 4) begin
            @(negedge Clock);
            if (DRAMReadDataValid) pulses++;
        end
        DRAMCommandValid = 1'b0;
        tests++;
        if (pulses != 0) begin fails++; $display("FAIL noop_ignored got pulses=%0d exp=0", pulses); end
    endtask

    task automatic test_write_read;
        int lat;
        logic [511:0] d;
        do_write(28'h40, pat_5a, 64'h0, 1'b1);
        do_read(28'h40, lat, d);
        tests++;
        if (lat != LAT) begin fails++; $display("FAIL wr_rd_latency got=%0d exp=%0d", lat, LAT); end
        tests++;
        if (d !== pat_5a) begin fails++; $display("FAIL wr_rd_data got=%h exp=%h", d[63:0], pat_5a[63:0]); end
        do_read(28'h2040, lat, d);
        tests++;
        if (lat != LAT || d !== pat_5a) begin
            fails++; $display("FAIL addr_wrap got lat=%0d data=%h exp lat=%0d data=%h", lat, d[63:0], LAT, pat_5a[63:0]);
        end
    endtask

    task automatic test_mask;
        int lat;
        logic [511:0] d;
        do_write(28'h0, {512{1'b1}}, 64'h0, 1'b1);
        do_write(28'h0, 512'h0, ~64'h1, 1'b1);
        do_read(28'h0, lat, d);
        tests++;
        if (lat != LAT || d !== pat_ff00) begin
            fails++; $display("FAIL byte_mask got lat=%0d data=%h exp lat=%0d data=%h", lat, d[63:0], LAT, pat_ff00[63:0]);
        end
    endtask

    task automatic test_bypass;
        int lat;
        logic [511:0] d;
        @(negedge Clock);
        DRAMAddress = 28'h80; DRAMCommand = WR; DRAMCommandValid = 1'b1;
        DRAMWriteData = pat_byp; DRAMWriteMask = '0; DRAMWriteDataValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (DRAMCommandReady !== 1'b0) begin fails++; $display("FAIL nodata_ready cycle=%0d got=%b exp=0", i, DRAMCommandReady); end
            @(posedge Clock);
            @(negedge Clock);
        end
        DRAMWriteDataValid = 1'b1;
        #1;
        tests++;
        if (DRAMCommandReady !== 1'b1 || DRAMWriteDataReady !== 1'b1) begin
            fails++; $display("FAIL bypass_ready got cmd=%b wd=%b exp 1/1", DRAMCommandReady, DRAMWriteDataReady);
        end
        @(posedge Clock);
        @(negedge Clock);
        DRAMCommandValid = 1'b0; DRAMWriteDataValid = 1'b0;
        do_read(28'h80, lat, d);
        tests++;
        if (lat != LAT || d !== pat_byp) begin
            fails++; $display("FAIL bypass_data got lat=%0d data=%h exp lat=%0d data=%h", lat, d[63:0], LAT, pat_byp[63:0]);
        end
    endtask

    task automatic test_fifo_full;
        logic [511:0] beat [4];
        int lat;
        logic [511:0] d;
        for (int j = 0; j < 4; j++) beat[j] = {16{32'hC0DE0000 + 32'(j)}};
        for (int j = 0; j < 4; j++) begin
            @(negedge Clock);
            DRAMWriteData = beat[j]; DRAMWriteMask = '0; DRAMWriteDataValid = 1'b1;
            #1;
            tests++;
            if (DRAMWriteDataReady !== 1'b1) begin fails++; $display("FAIL fifo_fill_ready beat=%0d got=%b exp=1", j, DRAMWriteDataReady); end
            @(posedge Clock);
        end
        @(negedge Clock);
        DRAMWriteDataValid = 1'b0;
        #1;
        tests++;
        if (DRAMWriteDataReady !== 1'b0) begin fails++; $display("FAIL fifo_full_ready got=%b exp=0", DRAMWriteDataReady); end
        DRAMAddress = 28'hC0; DRAMCommand = WR; DRAMCommandValid = 1'b1;
        #1;
        tests++;
        if (DRAMCommandReady !== 1'b1) begin fails++; $display("FAIL full_cmd_ready got=%b exp=1", DRAMCommandReady); end
        @(posedge Clock);
        @(negedge Clock);
        DRAMCommandValid = 1'b0;
        #1;
        tests++;
        if (DRAMWriteDataReady !== 1'b1) begin fails++; $display("FAIL after_pop_ready got=%b exp=1", DRAMWriteDataReady); end
        do_write(28'hC8, '0, '0, 1'b0);
        do_write(28'hD0, '0, '0, 1'b0);
        do_write(28'hD8, '0, '0, 1'b0);
        do_read(28'hC0, lat, d);
        tests++;
        if (lat != LAT || d !== beat[0]) begin fails++; $display("FAIL fifo_order0 got lat=%0d data=%h exp=%h", lat, d[63:0], beat[0][63:0]); end
        do_read(28'hD8, lat, d);
        tests++;
        if (lat != LAT || d !== beat[3]) begin fails++; $display("FAIL fifo_order3 got lat=%0d data=%h exp=%h", lat, d[63:0], beat[3][63:0]); end
    endtask

    task automatic test_write_first;
        logic [511:0] fresh;
        int lat;
        fresh = {8{64'h0123456789ABCDEF}};
        do_write(28'h100, {16{32'hDEADBEEF}}, 64'h0, 1'b1);
        @(negedge Clock);
        DRAMAddress = 28'h100; DRAMCommand = WR; DRAMCommandValid = 1'b1;
        DRAMWriteData = fresh; DRAMWriteMask = '0; DRAMWriteDataValid = 1'b1;
        #1;
        tests++;
        if (DRAMCommandReady !== 1'b1) begin fails++; $display("FAIL wf_write_ready got=%b exp=1", DRAMCommandReady); end
        @(posedge Clock);
        @(negedge Clock);
        DRAMWriteDataValid = 1'b0; DRAMCommand = RD;
        #1;
        tests++;
        if (DRAMCommandReady !== 1'b1) begin fails++; $display("FAIL wf_read_ready got=%b exp=1", DRAMCommandReady); end
        @(posedge Clock);
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge Clock);
            DRAMCommandValid = 1'b0;
            if (DRAMReadDataValid) begin
                lat = k;
                tests++;
                if (DRAMReadData !== fresh) begin fails++; $display("FAIL write_first_data got=%h exp=%h", DRAMReadData[63:0], fresh[63:0]); end
            end
        end
        tests++;
        if (lat != LAT) begin fails++; $display("FAIL write_first_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_back_to_back;
        logic [27:0]  addrs [3];
        logic [511:0] exps  [3];
        addrs[0] = 28'h40; addrs[1] = 28'h0; addrs[2] = 28'h80;
        exps[0]  = pat_5a; exps[1]  = pat_ff00; exps[2] = pat_byp;
        @(negedge Clock);
        for (int n = 0; n < 14; n++) begin
            if (n < 3) begin
                DRAMCommand = RD; DRAMAddress = addrs[n]; DRAMCommandValid = 1'b1;
                #1;
                tests++;
                if (DRAMCommandReady !== 1'b1) begin fails++; $display("FAIL b2b_ready n=%0d got=%b exp=1", n, DRAMCommandReady); end
            end else begin
                DRAMCommandValid = 1'b0;
            end
            tests++;
            if (DRAMReadDataValid !== (n >= LAT && n < LAT + 3)) begin
                fails++; $display("FAIL b2b_valid n=%0d got=%b exp=%b", n, DRAMReadDataValid, n >= LAT && n < LAT + 3);
            end else if (n >= LAT && n < LAT + 3) begin
                tests++;
                if (DRAMReadData !== exps[n-LAT]) begin fails++; $display("FAIL b2b_data n=%0d got=%h exp=%h", n, DRAMReadData[63:0], exps[n-LAT][63:0]); end
            end
            @(posedge Clock);
            @(negedge Clock);
        end
    endtask

    task automatic test_mid_reset;
        int pulses;
        int lat;
        logic [511:0] d;
        pulses = 0;
        @(negedge Clock);
        for (int n = 0; n < 16; n++) begin
            if (n < 3) begin
                DRAMCommand = RD; DRAMAddress = 28'h40; DRAMCommandValid = 1'b1;
            end else begin
                DRAMCommandValid = 1'b0;
            end
            if (n == 3) Reset = 1'b0;
            if (n == 5) Reset = 1'b1;
            if (DRAMReadDataValid) pulses++;
            if (n == 4) begin
                tests++;
                if (DRAMInitComplete !== 1'b0) begin fails++; $display("FAIL midreset_init got=%b exp=0", DRAMInitComplete); end
            end
            @(posedge Clock);
            @(negedge Clock);
        end
        tests++;
        if (pulses != 0) begin fails++; $display("FAIL midreset_pulses got=%0d exp=0", pulses); end
        repeat (INIT) @(negedge Clock);
        tests++;
        if (DRAMInitComplete !== 1'b1) begin fails++; $display("FAIL reinit_complete got=%b exp=1", DRAMInitComplete); end
        do_read(28'h40, lat, d);
        tests++;
        if (lat != LAT || d !== pat_5a) begin
            fails++; $display("FAIL array_retained got lat=%0d data=%h exp lat=%0d data=%h", lat, d[63:0], LAT, pat_5a[63:0]);
        end
    endtask

    initial begin
        pat_5a   = {64{8'h5A}};
        pat_ff00 = {{63{8'hFF}}, 8'h00};
        pat_byp  = {16{32'h1234ABCD}};
        test_reset;
        test_init;
        test_write_read;
        test_mask;
        test_bypass;
        test_fifo_full;
        test_write_first;
        test_back_to_back;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
